// File: rtl/harness_exit_reporter_if.sv
// tohost write channel between the DUT (master) and the harness exit reporter (slave).
// The master presents valid/data; the transfer happens when ready is also high.
interface harness_exit_reporter_if #(
    parameter int DATA_W = 64
);
    logic              tohost_valid;
    logic              tohost_ready;
    logic [DATA_W-1:0] tohost_data;

    modport master (
        output tohost_valid,
        output tohost_data,
        input  tohost_ready
    );

    modport slave (
        input  tohost_valid,
        input  tohost_data,
        output tohost_ready
    );
endinterface

// File: rtl/harness_exit_reporter.sv
// Harness end of the pass/fail protocol: sequences the DUT reset release, watches tohost exit
// writes and a cycle watchdog, and holds a sticky success/failure result until board reset.
module harness_exit_reporter #(
    parameter int DATA_W     = 64,
    parameter int RESET_HOLD = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [63:0]            max_cycles,
    harness_exit_reporter_if.slave host,
    output logic                   dut_reset,
    output logic                   running,
    output logic                   success,
    output logic                   failure,
    output logic                   timeout,
    output logic [DATA_W-2:0]      exit_code,
    output logic [63:0]            cycle_count
);
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PASS = 2'd2;
    localparam logic [1:0] ST_FAIL = 2'd3;

    logic [1:0]        state_q,       state_d;
    logic [HOLD_W-1:0] hold_cnt_q,    hold_cnt_d;
    logic              dut_reset_q,   dut_reset_d;
    logic              success_q,     success_d;
    logic              failure_q,     failure_d;
    logic              timeout_q,     timeout_d;
    logic [DATA_W-2:0] exit_code_q,   exit_code_d;
    logic [63:0]       cycle_count_q, cycle_count_d;

    logic xfer;
    logic exit_write;
    logic watchdog_expired;

    assign xfer             = host.tohost_valid && host.tohost_ready;
    assign exit_write       = xfer && host.tohost_data[0];
    assign watchdog_expired = (max_cycles != 64'd0) && (cycle_count_q > max_cycles);

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        success_d     = success_q;
        failure_d     = failure_q;
        timeout_d     = timeout_q;
        exit_code_d   = exit_code_q;
        cycle_count_d = cycle_count_q;

        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (cycle_count_q != {64{1'b1}}) begin
                    cycle_count_d = cycle_count_q + 64'd1;
                end
                // An exit write in the expiry cycle takes priority over the watchdog.
                if (exit_write) begin
                    exit_code_d = host.tohost_data[DATA_W-1:1];
                    if (host.tohost_data[DATA_W-1:1] == '0) begin
                        state_d   = ST_PASS;
                        success_d = 1'b1;
                    end else begin
                        state_d   = ST_FAIL;
                        failure_d = 1'b1;
                    end
                end else if (watchdog_expired) begin
                    state_d   = ST_FAIL;
                    failure_d = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                // PASS and FAIL are terminal; writes are still accepted and dropped.
            end
        endcase

        dut_reset_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            dut_reset_q   <= 1'b1;
            success_q     <= 1'b0;
            failure_q     <= 1'b0;
            timeout_q     <= 1'b0;
            exit_code_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            dut_reset_q   <= dut_reset_d;
            success_q     <= success_d;
            failure_q     <= failure_d;
            timeout_q     <= timeout_d;
            exit_code_q   <= exit_code_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign host.tohost_ready = (state_q != ST_HOLD);
    assign running           = (state_q == ST_RUN);
    assign dut_reset         = dut_reset_q;
    assign success           = success_q;
    assign failure           = failure_q;
    assign timeout           = timeout_q;
    assign exit_code         = exit_code_q;
    assign cycle_count       = cycle_count_q;
endmodule

// File: tb/tb_harness_exit_reporter.sv
// Bench for harness_exit_reporter: each scenario's outcome (which event ends RUN, when, and
// what the frozen outputs become) is worked out arithmetically from the write schedule.
module tb_harness_exit_reporter;
    localparam int    DATA_W = 64;
    localparam int    HOLD   = 16;
    localparam longint NEVER = 64'sd1 << 40;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [63:0]       max_cycles = '0;
    logic              dut_reset, running, success, failure, timeout;
    logic [DATA_W-2:0] exit_code;
    logic [63:0]       cycle_count;

    int total = 0;
    int bad   = 0;

    harness_exit_reporter_if #(.DATA_W(DATA_W)) th ();

    harness_exit_reporter #(.DATA_W(DATA_W), .RESET_HOLD(HOLD)) dut (
        .clock       (clock),
        .reset       (reset),
        .max_cycles  (max_cycles),
        .host        (th.slave),
        .dut_reset   (dut_reset),
        .running     (running),
        .success     (success),
        .failure     (failure),
        .timeout     (timeout),
        .exit_code   (exit_code),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    // Reset for rst_len edges, release, then hold + run_len cycles. exit_at is the RUN-cycle
    // index of the exit write (-1 = none); other writes before the end carry bit0=0.
    task automatic run_case(input string name, input int rst_len, input logic [63:0] max_c,
                            input int exit_at, input logic [63:0] exit_data,
                            input int run_len, input int noise_pct);
        longint      e, w, fin;
        bit          term, is_to, is_pass, done;
        logic [62:0] exp_code, exp_code_now;
        logic [5:0]  got_v, exp_v;
        logic [63:0] exp_cnt;
        int          i;

        e   = (exit_at >= 0) ? longint'(exit_at) : NEVER;
        w   = (max_c != 64'd0 && max_c < 64'd1000000) ? longint'(max_c) + 1 : NEVER;
        fin = (e <= w) ? e : w;
        term     = fin < run_len;
        is_to    = term && (w < e);
        exp_code = (term && !is_to) ? exit_data[63:1] : 63'd0;
        is_pass  = term && !is_to && (exp_code == 63'd0);

        @(negedge clock);
        reset = 1'b0;
        max_cycles = max_c;
        th.tohost_valid = 1'($urandom_range(0, 1));
        th.tohost_data  = {$urandom, $urandom};
        repeat (rst_len) @(posedge clock);
        @(negedge clock);

        total++;
        got_v = {dut_reset, th.tohost_ready, running, success, failure, timeout};
        if (got_v !== 6'b100000) begin
            bad++;
            $display("FAIL %s reset_flags {dr,rdy,run,ok,fail,to} got=%b want=100000", name, got_v);
        end
        total++;
        if (cycle_count !== 64'd0 || exit_code !== 63'd0) begin
            bad++;
            $display("FAIL %s reset_values cnt=%0d code=%0d want 0/0", name, cycle_count, exit_code);
        end

        reset = 1'b1;
        for (int k = 0; k < HOLD + run_len; k++) begin
            i    = k - HOLD;
            done = term && (i > fin);
            exp_cnt      = (i < 0) ? 64'd0 : (done ? 64'(fin + 1) : 64'(i));
            exp_code_now = done ? exp_code : 63'd0;
            exp_v = {k < HOLD, k >= HOLD, (i >= 0) && !done,
                     done && is_pass, done && !is_pass, done && is_to};
            got_v = {dut_reset, th.tohost_ready, running, success, failure, timeout};

            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL %s flags k=%0d {dr,rdy,run,ok,fail,to} got=%b want=%b",
                         name, k, got_v, exp_v);
            end
            total++;
            if (cycle_count !== exp_cnt) begin
                bad++;
                $display("FAIL %s cycle_count k=%0d got=%0d want=%0d", name, k, cycle_count, exp_cnt);
            end
            total++;
            if (exit_code !== exp_code_now) begin
                bad++;
                $display("FAIL %s exit_code k=%0d got=%0d want=%0d", name, k, exit_code, exp_code_now);
            end

            if (i >= 0 && i == exit_at) begin
                th.tohost_valid = 1'b1;
                th.tohost_data  = exit_data;
            end else if (i < 0 || done) begin
                th.tohost_valid = ($urandom_range(0, 99) < noise_pct);
                th.tohost_data  = $urandom_range(0, 1) ? 64'h1 : {$urandom, $urandom};
            end else begin
                th.tohost_valid = ($urandom_range(0, 99) < noise_pct);
                th.tohost_data  = {$urandom, $urandom} & ~64'h1;
            end
            if (th.tohost_valid && i >= 0)
                $display("txn %s run_cycle=%0d data=0x%h", name, i, th.tohost_data);
            @(negedge clock);
        end
        th.tohost_valid = 1'b0;
        $display("case %s: max=%0d exit_at=%0d end=%0d pass=%0b timeout=%0b",
                 name, max_c, exit_at, term ? fin : -1, is_pass, is_to);
    endtask

    task automatic test_reset();
        run_case("reset_hold", 3, 64'd0, -1, 64'd0, 6, 50);
    endtask

    task automatic test_pass();
        run_case("pass", 2, 64'd0, int'($urandom_range(3, 20)), 64'h1, 40, 30);
    endtask

    task automatic test_fail_code();
        run_case("fail_code", 2, 64'd0, int'($urandom_range(3, 20)), 64'h7, 50, 60);
    endtask

    task automatic test_watchdog();
        run_case("watchdog", 2, 64'd100, -1, 64'd0, 110, 20);
    endtask

    task automatic test_no_watchdog();
        run_case("no_watchdog", 2, 64'd0, -1, 64'd0, 10000, 0);
    endtask

    task automatic test_tie();
        int m;
        m = int'($urandom_range(20, 60));
        run_case("exit_at_expiry", 2, 64'(m), m + 1, 64'h1, m + 10, 40);
    endtask

    task automatic test_reset_from_fail();
        run_case("to_fail", 2, 64'd0, 5, 64'({$urandom_range(1, 1000), 1'b1}), 15, 30);
        run_case("after_fail_reset", 1, 64'd0, int'($urandom_range(2, 10)), 64'h1, 20, 30);
    endtask

    task automatic test_random();
        logic [63:0] m, d;
        int          ex;
        for (int n = 0; n < 8; n++) begin
            m  = $urandom_range(0, 1) ? 64'd0 : 64'($urandom_range(5, 80));
            ex = int'($urandom_range(0, 90)) - 1;
            d  = $urandom_range(0, 1) ? 64'h1 : 64'({$urandom_range(0, 255), 1'b1});
            run_case($sformatf("random%0d", n), int'($urandom_range(1, 4)), m, ex, d, 100, 25);
        end
    endtask

    initial begin
        th.tohost_valid = 1'b0;
        th.tohost_data  = '0;
        test_reset();
        test_pass();
        test_fail_code();
        test_watchdog();
        test_no_watchdog();
        test_tie();
        test_reset_from_fail();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
